// File: rtl/sram_like_arb_pkg.sv
// rtl/sram_like_arb_pkg.sv - shared command layout, owner encodings and grant states
package sram_like_arb_pkg;

  localparam int CMD_LEN   = 71;
  localparam int CMD_WDATA = 0;
  localparam int CMD_ADDR  = 32;
  localparam int CMD_WSTRB = 64;
  localparam int CMD_SIZE  = 68;
  localparam int CMD_WR    = 70;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef logic [CMD_LEN-1:0] cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK_I,
    ST_LOCK_D
  } arb_state_e;

endpackage

// File: rtl/sram_like_arb_if.sv
// rtl/sram_like_arb_if.sv - one sram-like port: request/command out, accept/response back
interface sram_like_arb_if;
  import sram_like_arb_pkg::*;

  logic        req;
  cmd_t        cmd_zip;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (output req, output cmd_zip, input addr_ok, input data_ok, input rdata);
  modport slave  (input req, input cmd_zip, output addr_ok, output data_ok, output rdata);

endinterface

// File: rtl/sram_like_arb_owner_fifo.sv
// rtl/sram_like_arb_owner_fifo.sv - in-order FIFO of 1-bit owner tags for outstanding transactions
module sram_like_arb_owner_fifo #(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          push_owner,
  input  logic          pop,
  output logic          head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_owner;
    end
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/sram_like_arb.sv
// rtl/sram_like_arb.sv - 2:1 inst/data sram-like arbiter with grant lock and in-order response routing
module sram_like_arb
  import sram_like_arb_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_like_arb_if.slave         inst_if,
  sram_like_arb_if.slave         data_if,
  sram_like_arb_if.master        mem_if
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

  arb_state_e    state_q, state_d;
  logic          ready_q, ready_d;
  logic          active;
  logic          sel_data;
  logic          sel_req;
  logic          mem_req;
  logic          accept;
  logic          pop;
  logic          fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  // ready_q keeps every output quiet for one cycle after reset falls.
  always_comb begin
    ready_d  = 1'b1;
    active   = ready_q & ~reset;
    case (state_q)
      ST_LOCK_I: sel_data = 1'b0;
      ST_LOCK_D: sel_data = 1'b1;
      default:   sel_data = data_if.req;
    endcase
    sel_req = sel_data ? data_if.req : inst_if.req;
    mem_req = active & sel_req & ~fifo_full;
    accept  = mem_req & mem_if.addr_ok;
    pop     = active & mem_if.data_ok & ~fifo_empty;

    state_d = state_q;
    if (state_q == ST_IDLE) begin
      if (mem_req && !mem_if.addr_ok) begin
        state_d = sel_data ? ST_LOCK_D : ST_LOCK_I;
      end
    end else if (accept) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  sram_like_arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_owner (sel_data ? OWN_DATA : OWN_INST),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  assign mem_if.req     = mem_req;
  assign mem_if.cmd_zip = sel_data ? data_if.cmd_zip : inst_if.cmd_zip;

  assign inst_if.addr_ok = accept & ~sel_data;
  assign data_if.addr_ok = accept & sel_data;

  assign inst_if.data_ok = pop & (fifo_head == OWN_INST);
  assign data_if.data_ok = pop & (fifo_head == OWN_DATA);

  assign inst_if.rdata = mem_if.rdata;
  assign data_if.rdata = mem_if.rdata;

  // A response with nothing outstanding means the memory broke ordering.
  always @(posedge clk) begin
    if (!reset && ready_q) begin
      assert (!(mem_if.data_ok && fifo_empty));
      assert (fifo_count <= CW'(MAX_OUTSTANDING));
    end
  end

endmodule

// File: tb/tb_sram_like_arb.sv
// tb/tb_sram_like_arb.sv - directed and randomized bench for sram_like_arb against a queue model
module tb_sram_like_arb;
  import sram_like_arb_pkg::*;

  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_like_arb_if inst_bus ();
  sram_like_arb_if data_bus ();
  sram_like_arb_if mem_bus ();

  sram_like_arb #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk     (clk),
    .reset   (reset),
    .inst_if (inst_bus),
    .data_if (data_bus),
    .mem_if  (mem_bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   q[$];
  int   locked;
  bit   ready;
  bit   e_req, e_sel, e_dv;
  cmd_t e_cmd;
  logic [31:0] m_rdata;

  function automatic cmd_t mk_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    mk_cmd = {wr, 2'b10, 4'hF, addr, wdata};
  endfunction

  function automatic cmd_t rand_cmd();
    rand_cmd = {1'($urandom_range(1)), 2'($urandom_range(3)), 4'($urandom_range(15)), $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ir, input logic dr, input logic aok, input logic dok);
    inst_bus.req     = ir;
    data_bus.req     = dr;
    mem_bus.addr_ok  = aok;
    mem_bus.data_ok  = dok;
    mem_bus.rdata    = m_rdata;
  endtask

  task automatic settle();
    bit en;
    #1;
    en    = ready && !reset;
    e_sel = (locked >= 0) ? (locked == 1) : data_bus.req;
    e_req = en && (e_sel ? data_bus.req : inst_bus.req) && (q.size() < MAXO);
    e_cmd = e_sel ? data_bus.cmd_zip : inst_bus.cmd_zip;
    e_dv  = en && mem_bus.data_ok && (q.size() > 0);
    chk("mem_req", 128'(mem_bus.req), 128'(e_req));
    if (e_req) chk("mem_cmd_zip", 128'(mem_bus.cmd_zip), 128'(e_cmd));
    chk("inst_addr_ok", 128'(inst_bus.addr_ok), 128'(e_req && mem_bus.addr_ok && !e_sel));
    chk("data_addr_ok", 128'(data_bus.addr_ok), 128'(e_req && mem_bus.addr_ok && e_sel));
    chk("inst_data_ok", 128'(inst_bus.data_ok), 128'(e_dv && q[0] == 0));
    chk("data_data_ok", 128'(data_bus.data_ok), 128'(e_dv && q[0] == 1));
    chk("inst_rdata", 128'(inst_bus.rdata), 128'(m_rdata));
    chk("data_rdata", 128'(data_bus.rdata), 128'(m_rdata));
    chk("count", 128'(dut.fifo_count), 128'(q.size()));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      q.delete();
      locked = -1;
      ready  = 1'b0;
    end else begin
      if (e_req && mem_bus.addr_ok) begin
        q.push_back(int'(e_sel));
        locked = -1;
      end else if (e_req) begin
        locked = int'(e_sel);
      end
      if (e_dv) void'(q.pop_front());
      ready = 1'b1;
    end
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    m_rdata = 32'h0;
    inst_bus.cmd_zip = mk_cmd(1'b0, 32'hBFC0_0000, 32'h0);
    data_bus.cmd_zip = mk_cmd(1'b0, 32'h1C00_0100, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    locked = -1;
    ready  = 1'b0;

    // reset held with requests present, then the quiet cycle after release
    step();
    reset = 1'b0;
    settle();
    chk("post_reset_mem_req", 128'(mem_bus.req), 128'(0));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // inst read: accept at cycle 0, response at cycle 2
    inst_bus.cmd_zip = mk_cmd(1'b0, 32'hBFC0_0380, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("t1_inst_addr_ok", 128'(inst_bus.addr_ok), 128'(1));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    m_rdata = 32'h1C80_0000;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("t1_inst_data_ok", 128'(inst_bus.data_ok), 128'(1));
    chk("t1_inst_rdata", 128'(inst_bus.rdata), 128'(32'h1C80_0000));
    chk("t1_data_data_ok", 128'(data_bus.data_ok), 128'(0));
    tick();

    // simultaneous requests: data first, then inst, responses in order
    data_bus.cmd_zip = mk_cmd(1'b1, 32'h1C00_0100, 32'hDEAD_BEEF);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("t2_data_addr", 128'(mem_bus.cmd_zip[CMD_ADDR +: 32]), 128'(32'h1C00_0100));
    chk("t2_data_addr_ok", 128'(data_bus.addr_ok), 128'(1));
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("t2_inst_addr_ok", 128'(inst_bus.addr_ok), 128'(1));
    tick();
    m_rdata = 32'h0000_1111;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    chk("t2_first_resp_data", 128'(data_bus.data_ok), 128'(1));
    tick();
    settle();
    chk("t2_second_resp_inst", 128'(inst_bus.data_ok), 128'(1));
    tick();

    // grant lock: inst stalls 3 cycles while data rises in cycle 1
    inst_bus.cmd_zip = mk_cmd(1'b0, 32'hBFC0_0400, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int c = 1; c < 3; c++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      settle();
      chk("t3_lock_cmd", 128'(mem_bus.cmd_zip), 128'(inst_bus.cmd_zip));
      chk("t3_data_held", 128'(data_bus.addr_ok), 128'(0));
      tick();
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    settle();
    chk("t3_inst_accept", 128'(inst_bus.addr_ok), 128'(1));
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    chk("t3_data_after", 128'(data_bus.addr_ok), 128'(1));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) step();

    // full: four accepted, fifth blocked even with a same-cycle pop
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (4) step();
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    settle();
    chk("t4_full_blocks", 128'(mem_bus.req), 128'(0));
    chk("t4_count_full", 128'(dut.fifo_count), 128'(4));
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    settle();
    chk("t4_reassert", 128'(mem_bus.req), 128'(1));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (4) step();

    // push+pop at count 2 across pointer wrap
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 6; i++) begin
      drive(i % 2 == 0, i % 2 != 0, 1'b1, 1'b1);
      step();
      chk("t5_count_steady", 128'(dut.fifo_count), 128'(2));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) step();

    // reset with three outstanding, stray response right after release
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) step();
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    repeat (2) step();
    reset = 1'b0;
    settle();
    chk("t6_no_inst_data_ok", 128'(inst_bus.data_ok), 128'(0));
    chk("t6_no_data_data_ok", 128'(data_bus.data_ok), 128'(0));
    chk("t6_count_zero", 128'(dut.fifo_count), 128'(0));
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // randomized traffic against the queue model
    for (int n = 0; n < 400; n++) begin
      logic ir, dr, aok, dok;
      if (locked != 0) inst_bus.cmd_zip = rand_cmd();
      if (locked != 1) data_bus.cmd_zip = rand_cmd();
      ir  = (locked == 0) ? 1'b1 : 1'($urandom_range(1));
      dr  = (locked == 1) ? 1'b1 : 1'($urandom_range(1));
      aok = 1'($urandom_range(1));
      dok = (q.size() > 0) ? 1'($urandom_range(1)) : 1'b0;
      m_rdata = $urandom;
      drive(ir, dr, aok, dok);
      step();
    end
    for (int n = 0; n < 20 && (q.size() > 0 || locked >= 0); n++) begin
      drive(locked == 0, locked == 1, 1'b1, q.size() > 0);
      step();
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("drain_empty", 128'(dut.fifo_count), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arb.md
Name: sram_like_arb

Overview:
- 2:1 arbiter that merges the core's instruction and data sram-like ports onto one sram-like master port, for a single-ported memory or a later AXI bridge.
- Sits directly downstream of the CPU top and consumes its inst_sram_* / data_sram_* traffic.
- Request path is combinational, with a grant lock that keeps the selected request stable until it is accepted.
- Tracks outstanding transactions in an in-order owner FIFO so each data_ok and rdata beat returns to the master that issued it.

Parameters:
MAX_OUTSTANDING, 4, depth of the owner FIFO, i.e. the maximum number of accepted transactions still waiting for data_ok (power of 2, at least 2).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  instruction master request
inst_cmd_zip  in  `CMD_LEN  packed {wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]}
inst_addr_ok  out  1  instruction request accepted
inst_data_ok  out  1  instruction response valid
inst_rdata  out  32  instruction read data
data_req  in  1  data master request
data_cmd_zip  in  `CMD_LEN  packed command, same layout as inst_cmd_zip
data_addr_ok  out  1  data request accepted
data_data_ok  out  1  data response valid
data_rdata  out  32  data read data
mem_req  out  1  merged request to memory
mem_cmd_zip  out  `CMD_LEN  packed command of the granted master
mem_addr_ok  in  1  memory accepted the request
mem_data_ok  in  1  memory response valid (in issue order)
mem_rdata  in  32  memory read data

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset).
- While reset is high, and on the first cycle after it falls:
  - state = IDLE, FIFO empty, count = 0;
  - mem_req = 0, every addr_ok = 0, every data_ok = 0.
- Grant FSM states are IDLE, LOCK_I and LOCK_D.
- In IDLE, sel = data when data_req is high, else inst (fixed priority, data first).
- In LOCK_I, sel = inst regardless of data_req. In LOCK_D, sel = data.
- FSM transitions:
  - IDLE -> LOCK_x when mem_req is high and mem_addr_ok is low.
  - LOCK_x -> IDLE on the cycle that mem_req & mem_addr_ok.
  - IDLE stays IDLE when the handshake completes in the same cycle.
- Request path:
  - mem_req = (sel master's req) & ~full.
  - mem_cmd_zip = sel master's cmd_zip; it is a pure mux with no register stage.
- addr_ok routing:
  - {sel}_addr_ok = mem_addr_ok & mem_req.
  - The non-selected master's addr_ok = 0.
- Accept handshake (mem_req & mem_addr_ok): push the owner bit (1 = data) at the tail. Zero-cycle latency.
- Response routing:
  - When mem_data_ok is high and the FIFO is not empty, pop the head.
  - head = 1 -> data_data_ok = 1. head = 0 -> inst_data_ok = 1.
  - The other master's data_ok = 0.
  - inst_rdata = data_rdata = mem_rdata (broadcast). Masters qualify it with their own data_ok.
- Full / empty:
  - full = (count == MAX_OUTSTANDING), taken from the registered count.
  - full blocks mem_req even if a pop happens in the same cycle.
  - Push and pop in the same cycle leave count unchanged; the pointers wrap modulo MAX_OUTSTANDING.
- Protocol violation: mem_data_ok while the FIFO is empty.
  - No pop, both data_ok = 0.
  - A simulation-only assertion fires.
- Master withdrawal: a master that drops req while locked is a protocol violation. The FSM stays locked until the handshake completes.
- Pipeline flushes are not visible here. Every accepted transaction still receives its data_ok; discarding it is the stages' job.
- Reset mid-operation: outstanding entries are discarded. The memory is reset by the same reset.

Decomposition:
- Add to macro.h:
  - `CMD_LEN = 71;
  - field offsets CMD_WR, CMD_SIZE, CMD_WSTRB, CMD_ADDR, CMD_WDATA;
  - owner encodings OWN_INST = 0, OWN_DATA = 1.
- Sub-module owner_fifo (width 1, depth MAX_OUTSTANDING) provides push, pop, head, full, empty and count.
- The arbiter FSM and routing logic stay in sram_like_arb.

Test Plan:
- Inst read only, mem_addr_ok on the first cycle, data_ok 2 cycles later with rdata 0x1C800000:
  - inst_addr_ok pulses in cycle 0;
  - inst_data_ok pulses in cycle 2 with inst_rdata = 0x1C800000;
  - data_* outputs stay 0 throughout.
- inst_req and data_req asserted together:
  - data is granted first and mem_cmd_zip carries data addr 0x1C000100;
  - inst is granted on the next cycle;
  - responses return in order: data_data_ok, then inst_data_ok.
- Inst granted with mem_addr_ok held low for 3 cycles, and data_req rising in cycle 1:
  - mem_cmd_zip holds the inst command until acceptance (LOCK_I);
  - data is granted only afterwards.
- Issue 4 accepted requests with no data_ok:
  - mem_req = 0 on the 5th request;
  - one data_ok pops a slot and mem_req re-asserts on the next cycle.
- Push and pop in the same cycle at count = 2: count stays 2 and the head-owner routing stays correct across pointer wrap.
- Assert reset with 3 transactions outstanding:
  - in the cycle after reset falls, all outputs are 0 and count = 0;
  - a stray mem_data_ok is ignored with no data_ok pulse.
